memory_interface: RTL and testbench

//  Memory-side partner of the control unit. Serves every instruction fetch and load/store: samples the level

---
 rtl/memory_interface_pkg.sv | 33 +++
 rtl/memory_interface_load_extender.sv | 27 ++
 rtl/memory_interface.sv | 166 ++++++++++++++++
 tb/tb_memory_interface.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_interface_pkg.sv
// Shared definitions for the memory interface: size codes, FSM states and
// access-rule helpers used by the top and the load extender.
package memory_interface_pkg;

    localparam int DEF_XLEN       = 64;
    localparam int DEF_BUS_ADDR_W = 32;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] a);
        case (size)
            SZ_H:    return a[0];
            SZ_W:    return |a[1:0];
            SZ_D:    return |a;
            default: return 1'b0;
        endcase
    endfunction

    // Byte enables for a store; wide accesses always use the full word.
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_B:    return 4'b0001 << lo;
            SZ_H:    return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/memory_interface_load_extender.sv
// Combinational load path: pick the addressed lane out of the bus word and
// sign- or zero-extend it to the datapath width.
module load_extender
    import memory_interface_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [31:0]     rdata,
    input  logic [1:0]      lo,
    input  logic [1:0]      size,
    input  logic            zext,
    output logic [XLEN-1:0] data
);

    logic [31:0] lane;

    always_comb begin
        lane = rdata >> {lo, 3'b000};
        case (size)
            SZ_B:    data = zext ? XLEN'(lane[7:0])  : XLEN'($signed(lane[7:0]));
            SZ_H:    data = zext ? XLEN'(lane[15:0]) : XLEN'($signed(lane[15:0]));
            SZ_W:    data = zext ? XLEN'(lane)       : XLEN'($signed(lane));
            default: data = XLEN'(rdata);
        endcase
    end

endmodule

// File: rtl/memory_interface.sv
// Memory-side partner of the control unit: turns a held memory_start into one
// or two 32-bit bus beats and answers with a single-cycle memory_done.
module memory_interface
    import memory_interface_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int BUS_ADDR_W = DEF_BUS_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memory_start,
    input  logic                  sel_mem_operation,
    input  logic [1:0]            sel_mem_size,
    input  logic [2:0]            sel_mem_extension,
    input  logic [XLEN-1:0]       address,
    input  logic [XLEN-1:0]       write_data,
    output logic                  memory_done,
    output logic [XLEN-1:0]       read_data,
    output logic                  misaligned,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [BUS_ADDR_W-1:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [31:0]           bus_wdata,
    input  logic [31:0]           bus_rdata,
    input  logic                  bus_ack
);

    state_e                state_q, state_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic [BUS_ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]            bus_be_q, bus_be_d;
    logic [31:0]           bus_wdata_q, bus_wdata_d;
    logic [XLEN-1:0]       read_data_q, read_data_d;
    logic                  done_q, done_d;
    logic                  mis_q, mis_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            lo_q, lo_d;
    logic                  zext_q, zext_d;
    logic [31:0]           lo_word_q, lo_word_d;
    logic [31:0]           wdata0;
    logic [XLEN-1:0]       ext_data;
    logic                  unused_ok;

    assign unused_ok = ^{address[XLEN-1:BUS_ADDR_W], sel_mem_extension[1:0]};

    load_extender #(.XLEN(XLEN)) u_load_extender (
        .rdata (bus_rdata),
        .lo    (lo_q),
        .size  (size_q),
        .zext  (zext_q),
        .data  (ext_data)
    );

    always_comb begin
        case (sel_mem_size)
            SZ_B:    wdata0 = 32'(write_data[7:0])  << {address[1:0], 3'b000};
            SZ_H:    wdata0 = 32'(write_data[15:0]) << {address[1:0], 3'b000};
            default: wdata0 = write_data[31:0];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        read_data_d = read_data_q;
        done_d      = 1'b0;
        mis_d       = 1'b0;
        size_d      = size_q;
        lo_d        = lo_q;
        zext_d      = zext_q;
        lo_word_d   = lo_word_q;
        case (state_q)
            IDLE: if (memory_start) begin
                if (is_misaligned(sel_mem_size, address[2:0])) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    mis_d   = 1'b1;
                end else begin
                    state_d     = BEAT0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = sel_mem_operation;
                    bus_addr_d  = {address[BUS_ADDR_W-1:2], 2'b00};
                    bus_be_d    = sel_mem_operation ? store_be(sel_mem_size, address[1:0]) : 4'b0000;
                    bus_wdata_d = sel_mem_operation ? wdata0 : 32'h0;
                    size_d      = sel_mem_size;
                    lo_d        = address[1:0];
                    zext_d      = sel_mem_extension[2];
                end
            end
            BEAT0: if (bus_ack) begin
                if (size_q == SZ_D) begin
                    // request stays up; only the beat-specific fields move on
                    state_d     = BEAT1;
                    bus_addr_d  = bus_addr_q + BUS_ADDR_W'(4);
                    bus_wdata_d = bus_we_q ? write_data[63:32] : 32'h0;
                    lo_word_d   = bus_rdata;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (!bus_we_q) read_data_d = ext_data;
                end
            end
            BEAT1: if (bus_ack) begin
                state_d = DONE;
                done_d  = 1'b1;
                if (!bus_we_q) read_data_d = XLEN'({bus_rdata, lo_word_q});
            end
            default: state_d = IDLE;
        endcase
        if (state_d == DONE) begin
            bus_req_d   = 1'b0;
            bus_we_d    = 1'b0;
            bus_addr_d  = '0;
            bus_be_d    = 4'b0000;
            bus_wdata_d = 32'h0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
            read_data_q <= '0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            size_q      <= SZ_B;
            lo_q        <= 2'b00;
            zext_q      <= 1'b0;
            lo_word_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            read_data_q <= read_data_d;
            done_q      <= done_d;
            mis_q       <= mis_d;
            size_q      <= size_d;
            lo_q        <= lo_d;
            zext_q      <= zext_d;
            lo_word_q   <= lo_word_d;
        end
    end

    assign memory_done = done_q;
    assign misaligned  = mis_q;
    assign read_data   = read_data_q;
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_memory_interface.sv
// Bench for memory_interface: byte-level memory model acts as the bus slave,
// expectations come from access rules on bytes, not from the FSM.
module tb_memory_interface;

    logic        clk = 1'b0;
    logic        reset;
    logic        memory_start;
    logic        sel_mem_operation;
    logic [1:0]  sel_mem_size;
    logic [2:0]  sel_mem_extension;
    logic [63:0] address, write_data, read_data;
    logic        memory_done, misaligned;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    memory_interface dut (
        .clk(clk), .reset(reset), .memory_start(memory_start),
        .sel_mem_operation(sel_mem_operation), .sel_mem_size(sel_mem_size),
        .sel_mem_extension(sel_mem_extension), .address(address), .write_data(write_data),
        .memory_done(memory_done), .read_data(read_data), .misaligned(misaligned),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    bit [7:0]    mem [bit [31:0]];
    logic [63:0] exp_rd;
    int          done_cyc, done_cnt;
    logic        mis_obs;
    bit          req_seen;
    logic [31:0] b_addr[$];
    logic [3:0]  b_be[$];
    logic [31:0] b_wd[$];
    logic        b_we[$];

    function automatic bit [7:0] mbyte(input bit [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'((a * 32'd37) ^ 32'h5A);
    endfunction

    // Little-endian value of an n-byte access, extended as the load rules say.
    function automatic logic [63:0] model_load(input bit [1:0] sz, input bit [2:0] ext, input bit [63:0] a);
        logic [63:0] v;
        int n;
        n = 1 << sz;
        v = 64'h0;
        for (int i = 0; i < n; i++) v = v | (64'(mbyte(32'(a) + 32'(i))) << (8 * i));
        if (sz != 2'b11 && !ext[2] && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    // Drives one access and acts as the bus slave with 'waits' idle cycles per beat.
    task automatic access(input bit we, input bit [1:0] sz, input bit [2:0] ext,
                          input bit [63:0] a, input bit [63:0] wd, input int waits);
        int wcnt;
        wcnt = 0; done_cyc = -1; done_cnt = 0; req_seen = 0; mis_obs = 0;
        b_addr.delete(); b_be.delete(); b_wd.delete(); b_we.delete();
        memory_start = 1'b1; sel_mem_operation = we; sel_mem_size = sz;
        sel_mem_extension = ext; address = a; write_data = wd; bus_ack = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            bus_ack = 1'b0;
            if (memory_done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = c; mis_obs = misaligned; end
                memory_start = 1'b0;
            end
            if (bus_req) begin
                req_seen = 1'b1;
                if (wcnt == waits) begin
                    bus_ack = 1'b1; wcnt = 0;
                    b_addr.push_back(bus_addr); b_be.push_back(bus_be);
                    b_wd.push_back(bus_wdata);  b_we.push_back(bus_we);
                    bus_rdata = {mbyte(bus_addr + 32'd3), mbyte(bus_addr + 32'd2),
                                 mbyte(bus_addr + 32'd1), mbyte(bus_addr)};
                    if (bus_we)
                        for (int j = 0; j < 4; j++)
                            if (bus_be[j]) mem[bus_addr + 32'(j)] = bus_wdata[8*j +: 8];
                end else begin
                    wcnt++;
                    bus_rdata = $urandom;
                end
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        memory_start = 1'b0; bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; memory_start = 0; sel_mem_operation = 0; sel_mem_size = 0;
        sel_mem_extension = 0; address = 0; write_data = 0; bus_rdata = 0; bus_ack = 0;
        exp_rd = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (memory_done !== 1'b0 || misaligned !== 1'b0) begin errors++;
            $display("FAIL reset_done: got done=%b mis=%b, want 0 0", memory_done, misaligned); end
        checks++; if (bus_req !== 1'b0 || bus_we !== 1'b0) begin errors++;
            $display("FAIL reset_req: got req=%b we=%b, want 0 0", bus_req, bus_we); end
        checks++; if ({bus_addr, bus_be, bus_wdata} !== 68'h0) begin errors++;
            $display("FAIL reset_bus: got addr=%h be=%b wdata=%h, want 0", bus_addr, bus_be, bus_wdata); end
        checks++; if (read_data !== 64'h0) begin errors++;
            $display("FAIL reset_rdata: got %h want 0", read_data); end
        reset = 1'b0;
    endtask

    task automatic test_lw();
        mem[32'h1000] = 8'h01; mem[32'h1001] = 8'h00; mem[32'h1002] = 8'h00; mem[32'h1003] = 8'h80;
        access(1'b0, 2'b10, 3'b010, 64'h1000, 64'h0, 0);
        exp_rd = 64'hFFFF_FFFF_8000_0001;
        checks++; if (done_cyc !== 2 || done_cnt !== 1) begin errors++;
            $display("FAIL lw_latency: got cycle %0d count %0d, want 2 1", done_cyc, done_cnt); end
        checks++; if (read_data !== exp_rd) begin errors++;
            $display("FAIL lw_data: got %h want %h", read_data, exp_rd); end
    endtask

    task automatic test_lbu();
        mem[32'h1000] = 8'h00; mem[32'h1001] = 8'h00; mem[32'h1002] = 8'h00; mem[32'h1003] = 8'hAB;
        access(1'b0, 2'b00, 3'b100, 64'h1003, 64'h0, 0);
        exp_rd = 64'h0000_0000_0000_00AB;
        checks++; if (b_addr.size() != 1 || b_addr[0] !== 32'h1000 || b_be[0] !== 4'b0000) begin errors++;
            $display("FAIL lbu_bus: got %0d beats addr=%h be=%b, want 1 1000 0000",
                     b_addr.size(), b_addr.size() ? b_addr[0] : 32'hx, b_be.size() ? b_be[0] : 4'hx); end
        checks++; if (read_data !== exp_rd) begin errors++;
            $display("FAIL lbu_data: got %h want %h", read_data, exp_rd); end
    endtask

    task automatic test_sd_waits();
        access(1'b1, 2'b11, 3'b011, 64'h2000, 64'h1122_3344_5566_7788, 3);
        checks++; if (b_addr.size() != 2) begin errors++;
            $display("FAIL sd_beats: got %0d beats want 2", b_addr.size()); end
        else begin
            checks++; if (b_addr[0] !== 32'h2000 || b_wd[0] !== 32'h5566_7788 || b_be[0] !== 4'hF || b_we[0] !== 1'b1) begin
                errors++; $display("FAIL sd_beat0: got %h %h %b %b want 2000 55667788 1111 1",
                                   b_addr[0], b_wd[0], b_be[0], b_we[0]); end
            checks++; if (b_addr[1] !== 32'h2004 || b_wd[1] !== 32'h1122_3344 || b_be[1] !== 4'hF || b_we[1] !== 1'b1) begin
                errors++; $display("FAIL sd_beat1: got %h %h %b %b want 2004 11223344 1111 1",
                                   b_addr[1], b_wd[1], b_be[1], b_we[1]); end
        end
        checks++; if (done_cyc !== 9 || done_cnt !== 1) begin errors++;
            $display("FAIL sd_done: got cycle %0d count %0d, want 9 1", done_cyc, done_cnt); end
        checks++; if (read_data !== exp_rd) begin errors++;
            $display("FAIL sd_rdata_hold: got %h want %h", read_data, exp_rd); end
    endtask

    task automatic test_misaligned();
        access(1'b1, 2'b01, 3'b001, 64'h2001, 64'hDEAD, 0);
        checks++; if (req_seen !== 1'b0) begin errors++;
            $display("FAIL sh_mis_req: bus_req seen, want none"); end
        checks++; if (done_cyc !== 1 || mis_obs !== 1'b1 || done_cnt !== 1) begin errors++;
            $display("FAIL sh_mis_done: got cycle %0d mis %b count %0d, want 1 1 1", done_cyc, mis_obs, done_cnt); end
        checks++; if (read_data !== exp_rd || misaligned !== 1'b0) begin errors++;
            $display("FAIL sh_mis_after: got rdata %h mis %b, want %h 0", read_data, misaligned, exp_rd); end
    endtask

    task automatic test_sb();
        access(1'b1, 2'b00, 3'b000, 64'h3002, 64'hFF, 0);
        checks++; if (b_addr.size() != 1 || b_be[0] !== 4'b0100 || b_wd[0][23:16] !== 8'hFF ||
                      b_we[0] !== 1'b1 || b_addr[0] !== 32'h3000) begin errors++;
            $display("FAIL sb_lane: got %0d beats be=%b lane=%h we=%b, want 1 0100 ff 1",
                     b_addr.size(), b_be.size() ? b_be[0] : 4'hx,
                     b_wd.size() ? b_wd[0][23:16] : 8'hx, b_we.size() ? b_we[0] : 1'bx); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] want;
        bit done_leak;
        memory_start = 1'b1; sel_mem_operation = 1'b0; sel_mem_size = 2'b11;
        sel_mem_extension = 3'b011; address = 64'h4000; bus_ack = 1'b0;
        @(posedge clk); #1;
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h4004) begin errors++;
            $display("FAIL rst_mid_beat1: got req %b addr %h, want 1 4004", bus_req, bus_addr); end
        reset = 1'b1; memory_start = 1'b0;
        #1;
        checks++; if (bus_req !== 1'b0 || memory_done !== 1'b0) begin errors++;
            $display("FAIL rst_mid_abort: got req %b done %b, want 0 0", bus_req, memory_done); end
        done_leak = 0;
        repeat (2) begin @(posedge clk); #1; if (memory_done) done_leak = 1; end
        reset = 1'b0; exp_rd = 64'h0;
        repeat (2) begin @(posedge clk); #1; if (memory_done || bus_req) done_leak = 1; end
        checks++; if (done_leak !== 1'b0 || read_data !== 64'h0) begin errors++;
            $display("FAIL rst_mid_idle: got leak %b rdata %h, want 0 0", done_leak, read_data); end
        want = model_load(2'b10, 3'b010, 64'h1000);
        access(1'b0, 2'b10, 3'b010, 64'h1000, 64'h0, 0);
        exp_rd = want;
        checks++; if (done_cyc !== 2 || read_data !== want) begin errors++;
            $display("FAIL rst_mid_next_lw: got cycle %0d rdata %h, want 2 %h", done_cyc, read_data, want); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            bit we; bit [1:0] sz; bit [2:0] ext; bit [63:0] a, wd;
            int waits, nb, lat, lo, idx; bit mis;
            logic [63:0] v; logic [3:0] ebe; logic [31:0] mask, ewd;
            we = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3)); ext = 3'($urandom_range(0, 7));
            a = 64'h5000 + 64'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            wd = {$urandom, $urandom}; waits = $urandom_range(0, 2);
            mis = (a % (64'd1 << sz)) != 0;
            nb = mis ? 0 : ((sz == 2'b11) ? 2 : 1);
            lat = 1 + nb * (waits + 1);
            lo = int'(a[1:0]);
            v = model_load(sz, ext, a);
            access(we, sz, ext, a, wd, waits);
            if (!we && !mis) exp_rd = v;
            checks++; if (done_cyc !== lat || done_cnt !== 1 || mis_obs !== mis) begin errors++;
                $display("FAIL rnd%0d_done: got cycle %0d count %0d mis %b, want %0d 1 %b",
                         it, done_cyc, done_cnt, mis_obs, lat, mis); end
            checks++; if (b_addr.size() != nb) begin errors++;
                $display("FAIL rnd%0d_beats: got %0d want %0d", it, b_addr.size(), nb); end
            else for (int k = 0; k < nb; k++) begin
                ebe = !we ? 4'h0 : (sz == 2'b00) ? 4'(1 << lo) : (sz == 2'b01) ? 4'(3 << lo) : 4'hF;
                mask = 32'h0; ewd = 32'h0;
                for (int j = 0; j < 4; j++) if (ebe[j]) begin
                    idx = 8 * (4 * k + j - lo);
                    mask[8*j +: 8] = 8'hFF;
                    ewd[8*j +: 8] = 8'(wd >> idx);
                end
                checks++;
                if (b_addr[k] !== 32'((a & ~64'd3) + 64'(4 * k)) || b_be[k] !== ebe || b_we[k] !== we ||
                    (b_wd[k] & mask) !== ewd) begin errors++;
                    $display("FAIL rnd%0d_beat%0d: got addr %h be %b we %b wd %h, want %h %b %b %h",
                             it, k, b_addr[k], b_be[k], b_we[k], b_wd[k] & mask,
                             32'((a & ~64'd3) + 64'(4 * k)), ebe, we, ewd); end
            end
            checks++; if (read_data !== exp_rd || misaligned !== 1'b0) begin errors++;
                $display("FAIL rnd%0d_rdata: got %h mis %b, want %h 0", it, read_data, misaligned, exp_rd); end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lbu();
        test_sd_waits();
        test_misaligned();
        test_sb();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
